// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 UART receiver feeding a small ready/valid byte FIFO.
// Define UART_RX_PARITY_EN to add a parity bit check (PARITY_ODD selects odd parity).
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_rx,
  output logic       io_deq_valid,
  input  logic       io_deq_ready,
  output logic [7:0] io_deq_bits,
  output logic       io_frame_err,
  output logic       io_overrun,
`ifdef UART_RX_PARITY_EN
  output logic       io_parity_err,
`endif
  output logic       io_busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SCW     = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int PW      = AW + 1;

  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [SCW-1:0] SC_HALF  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           r_state;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic [DCW-1:0]   r_div_cnt;
  logic [SCW-1:0]   r_scnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_shift;
  logic             r_push;
  logic [7:0]       r_push_data;
  logic             r_frame_err;
  logic             r_overrun;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bad;
  logic             r_parity_err;
`endif

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;

  logic             w_tick;
  logic             w_start_entry;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;

  // The line idles high, so the synchronizer also resets high to avoid a false start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= io_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_start_entry = (r_state == S_IDLE) && !r_rx_s;
  assign w_tick        = (r_div_cnt == DIV_LAST);

  // Restarting the divider on a start edge keeps the bit-centre samples aligned to the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_start_entry || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_scnt       <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state <= S_START;
            r_scnt  <= '0;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_scnt == SC_HALF) begin
              r_scnt  <= '0;
              r_idx   <= '0;
              r_state <= r_rx_s ? S_IDLE : S_DATA;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_scnt == SC_LAST) begin
              r_scnt         <= '0;
              r_shift[r_idx] <= r_rx_s;
              r_idx          <= r_idx + 1'b1;
              if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                r_state <= S_PARITY;
`else
                r_state <= S_STOP;
`endif
              end
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_tick) begin
            if (r_scnt == SC_LAST) begin
              r_scnt    <= '0;
              r_par_bad <= (^r_shift) ^ r_rx_s ^ PARITY_ODD;
              r_state   <= S_STOP;
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
`endif
        S_STOP: begin
          if (w_tick) begin
            if (r_scnt == SC_LAST) begin
              r_scnt      <= '0;
              r_state     <= S_IDLE;
              r_push_data <= r_shift;
              r_frame_err <= !r_rx_s;
`ifdef UART_RX_PARITY_EN
              r_parity_err <= r_par_bad;
              r_push       <= r_rx_s && !r_par_bad;
`else
              r_push       <= r_rx_s;
`endif
            end else begin
              r_scnt <= r_scnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && io_deq_ready;
  assign w_push_ok = r_push && (!w_full || w_pop);

  // A simultaneous pop frees the slot the write lands in, so a full FIFO can still accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_overrun <= r_push && w_full && !w_pop;
      if (w_push_ok) begin
        r_mem[r_wptr[AW-1:0]] <= r_push_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  assign io_deq_valid = !w_empty;
  assign io_deq_bits  = r_mem[r_rptr[AW-1:0]];
  assign io_frame_err = r_frame_err;
  assign io_overrun   = r_overrun;
  assign io_busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign io_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames against a queue-based receiver model.
// Runs with DIV=1, so each serial bit lasts exactly OVERSAMPLE clocks.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1_843_200;
  localparam int BAUD     = 115_200;
  localparam int OS       = 16;
  localparam int DEPTH    = 4;
  // Edges after the start bit is driven: 2 sync flops + 1 detect, half a bit, then 9 bit times.
  localparam int START_EDGE = 3;
  localparam int STOP_EDGE  = START_EDGE + OS / 2 + 9 * OS;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_rx;
  logic       io_deq_ready;
  logic       io_deq_valid;
  logic [7:0] io_deq_bits;
  logic       io_frame_err;
  logic       io_overrun;
  logic       io_busy;

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_rx        (io_rx),
    .io_deq_valid (io_deq_valid),
    .io_deq_ready (io_deq_ready),
    .io_deq_bits  (io_deq_bits),
    .io_frame_err (io_frame_err),
    .io_overrun   (io_overrun),
    .io_busy      (io_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         edgeNo;
    logic [7:0] data;
    bit         stopGood;
  } frame_t;

  typedef struct {
    int s;
    int e;
  } win_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  frame_t     pending[$];
  win_t       busyWin[$];
  logic [7:0] mq[$];
  logic [7:0] popLog[$];
  bit         pushPend = 1'b0;
  logic [7:0] pushByte = 8'h00;
  bit         expFrameErr = 1'b0;
  bit         expOverrun = 1'b0;
  bit         expBusy;
  bit         mPop;
  bit         mAccept;
  bit         prevValid = 1'b0;
  int         riseCyc = 0;
  int         lastStart = 0;
  int         frameErrSeen = 0;
  int         overrunSeen = 0;
  int         busyCycles = 0;
  int         validCycles = 0;
  int         readyPct = 50;
  bit         randDone;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkPops(input string name, input int n, input logic [31:0] expPacked);
    logic [31:0] got;
    checkOutput({name, "_count"}, 32'(popLog.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < popLog.size()) ? {24'h0, popLog[i]} : 32'hFFFF_FFFF;
      checkOutput({name, "_byte"}, got, {24'h0, expPacked[8*i +: 8]});
    end
  endtask

  // Receiver model: a frame's stop sample lands STOP_EDGE edges after its start, the push one edge later.
  always @(posedge clock) begin
    cyc = cyc + 1;
    expFrameErr = 1'b0;
    expOverrun  = 1'b0;
    if (!reset) begin
      mPop = (mq.size() != 0) && io_deq_ready;
      mAccept = pushPend && !(mq.size() == DEPTH && !mPop);
      if (pushPend && !mAccept) expOverrun = 1'b1;
      if (mPop) void'(mq.pop_front());
      if (mAccept) mq.push_back(pushByte);
      pushPend = 1'b0;
      if (pending.size() != 0 && pending[0].edgeNo == cyc) begin
        if (pending[0].stopGood) begin
          pushPend = 1'b1;
          pushByte = pending[0].data;
        end else begin
          expFrameErr = 1'b1;
        end
        void'(pending.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("deq_valid", 32'(io_deq_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) checkOutput("deq_bits", {24'h0, io_deq_bits}, {24'h0, mq[0]});
      checkOutput("frame_err", 32'(io_frame_err), 32'(expFrameErr));
      checkOutput("overrun", 32'(io_overrun), 32'(expOverrun));
      expBusy = 1'b0;
      foreach (busyWin[i]) if (busyWin[i].s <= cyc && cyc < busyWin[i].e) expBusy = 1'b1;
      checkOutput("busy", 32'(io_busy), 32'(expBusy));
      if (io_frame_err) frameErrSeen++;
      if (io_overrun) overrunSeen++;
      if (io_busy) busyCycles++;
      if (io_deq_valid) validCycles++;
      if (io_deq_valid && !prevValid) riseCyc = cyc;
      prevValid = io_deq_valid;
      if (io_deq_valid && io_deq_ready) popLog.push_back(io_deq_bits);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Sends one 10-bit frame; pulseAt >= 0 raises ready for exactly the cycle after that edge offset.
  task automatic applyStimulus(input logic [7:0] data, input bit stopGood, input int pulseAt);
    int k;
    @(posedge clock);
    #1;
    k = cyc;
    lastStart = k;
    pending.push_back('{k + STOP_EDGE, data, stopGood});
    busyWin.push_back('{k + START_EDGE, k + STOP_EDGE});
    if (!stopGood) busyWin.push_back('{k + STOP_EDGE + 1, k + STOP_EDGE + 1 + OS / 2});
    for (int c = 0; c < 10 * OS; c++) begin
      if (c < OS) io_rx = 1'b0;
      else if (c < 9 * OS) io_rx = data[c / OS - 1];
      else io_rx = stopGood;
      if (pulseAt >= 0) begin
        if (c == pulseAt) io_deq_ready = 1'b1;
        else if (c == pulseAt + 1) io_deq_ready = 1'b0;
      end
      @(posedge clock);
      #1;
    end
    io_rx = 1'b1;
    if (!stopGood) tick(12);
  endtask

  task automatic applyGlitch(input int lowLen);
    int k;
    @(posedge clock);
    #1;
    k = cyc;
    busyWin.push_back('{k + START_EDGE, k + START_EDGE + OS / 2});
    io_rx = 1'b0;
    tick(lowLen);
    io_rx = 1'b1;
    tick(16);
  endtask

  task automatic applyPartial(input logic [7:0] data, input int nCycles);
    int k;
    @(posedge clock);
    #1;
    k = cyc;
    busyWin.push_back('{k + START_EDGE, k + 1_000_000});
    for (int c = 0; c < nCycles; c++) begin
      io_rx = (c < OS) ? 1'b0 : data[(c / OS - 1) % 8];
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyReset(input int holdCycles);
    reset = 1'b1;
    io_rx = 1'b1;
    mq.delete();
    pending.delete();
    busyWin.delete();
    pushPend = 1'b0;
    expFrameErr = 1'b0;
    expOverrun = 1'b0;
    prevValid = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(io_deq_valid), 32'd0);
    checkOutput("reset_bits", {24'h0, io_deq_bits}, 32'h00);
    checkOutput("reset_frame_err", 32'(io_frame_err), 32'd0);
    checkOutput("reset_overrun", 32'(io_overrun), 32'd0);
    checkOutput("reset_busy", 32'(io_busy), 32'd0);
    tick(holdCycles);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    io_rx = 1'b1;
    io_deq_ready = 1'b0;
    tick(3);
    applyReset(2);
    tick(4);

    // 1: single byte with ready held high
    io_deq_ready = 1'b1;
    popLog.delete();
    frameErrSeen = 0;
    overrunSeen = 0;
    validCycles = 0;
    applyStimulus(8'hA5, 1'b1, -1);
    tick(10);
    checkOutput("t1_latency", 32'(riseCyc - lastStart), 32'd156);
    checkOutput("t1_valid_cycles", 32'(validCycles), 32'd1);
    checkPops("t1", 1, 32'h0000_00A5);
    checkOutput("t1_flags", 32'(frameErrSeen + overrunSeen), 32'd0);

    // 2: short low glitch is rejected
    popLog.delete();
    busyCycles = 0;
    applyGlitch(6);
    checkOutput("t2_busy_le8", 32'(busyCycles <= 8), 32'd1);
    checkOutput("t2_pops", 32'(popLog.size()), 32'd0);
    checkOutput("t2_flags", 32'(frameErrSeen + overrunSeen), 32'd0);

    // 3: stop bit low, then a clean frame
    applyStimulus(8'h3C, 1'b0, -1);
    checkOutput("t3_frame_err_pulses", 32'(frameErrSeen), 32'd1);
    checkOutput("t3_empty", 32'(io_deq_valid), 32'd0);
    applyStimulus(8'h11, 1'b1, -1);
    tick(5);
    checkPops("t3", 1, 32'h0000_0011);

    // 4: overfill with ready low, then drain
    io_deq_ready = 1'b0;
    popLog.delete();
    overrunSeen = 0;
    for (int b = 1; b <= 5; b++) applyStimulus(8'(b), 1'b1, -1);
    tick(4);
    checkOutput("t4_overrun_pulses", 32'(overrunSeen), 32'd1);
    io_deq_ready = 1'b1;
    tick(8);
    io_deq_ready = 1'b0;
    checkPops("t4", 4, 32'h0403_0201);

    // 5: full FIFO, pop exactly in the push cycle
    popLog.delete();
    for (int b = 1; b <= 4; b++) applyStimulus(8'(b), 1'b1, -1);
    overrunSeen = 0;
    applyStimulus(8'h55, 1'b1, STOP_EDGE);
    tick(4);
    checkOutput("t5_overrun_pulses", 32'(overrunSeen), 32'd0);
    checkPops("t5_pulse", 1, 32'h0000_0001);
    popLog.delete();
    io_deq_ready = 1'b1;
    tick(8);
    io_deq_ready = 1'b0;
    checkPops("t5_drain", 4, 32'h5504_0302);

    // 6: reset in the middle of a frame with a byte queued
    applyStimulus(8'h9A, 1'b1, -1);
    tick(3);
    applyPartial(8'hC3, 60);
    applyReset(2);
    tick(3);
    io_deq_ready = 1'b1;
    popLog.delete();
    applyStimulus(8'h7E, 1'b1, -1);
    tick(4);
    checkPops("t6", 1, 32'h0000_007E);

    // Randomized traffic with random consumer back-pressure
    randDone = 1'b0;
    fork
      begin
        while (!randDone) begin
          @(posedge clock);
          #1;
          io_deq_ready = ($urandom_range(0, 99) < readyPct);
        end
      end
      begin
        for (int n = 0; n < 30; n++) begin
          int r;
          readyPct = (n < 15) ? 10 : 70;
          r = $urandom_range(0, 9);
          if (r == 0) applyGlitch($urandom_range(1, 7));
          else applyStimulus(8'($urandom), r != 1, -1);
          tick($urandom_range(0, 12));
        end
        randDone = 1'b1;
      end
    join
    io_deq_ready = 1'b1;
    tick(10);
    checkOutput("final_empty", 32'(io_deq_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
